fifo_async_read_ctrl: RTL and testbench
=======================================

FIFO_ASYNC_READ_CTRL -- requirements
Module: fifo_async_read_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data word width.
REQ-002 Parameter PTR_WIDTH, default 4: pointer width including the wrap bit; memory depth is 2^(PTR_WIDTH-1).
REQ-003 Parameter AE_THRESH, default 1: almost-empty threshold in words.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port read_clk  in  1: read-domain clock.
REQ-006 Port nrst_in  in  1: asynchronous active-low reset.
REQ-007 Port read_in  in  1: consumer pops the word on data_out at this edge.
REQ-008 Port wptr_g_sync_in  in  PTR_WIDTH: write pointer (Gray), already synchronised to read_clk.
REQ-009 Port rdata_mem_in  in  WIDTH: memory read data, valid one cycle after rd_en_mem_out.
REQ-010 Port rd_en_mem_out  out  1: memory read strobe.
REQ-011 Port raddr_out  out  PTR_WIDTH-1: memory read address.
REQ-012 Port rptr_b_out / rptr_g_out  out  PTR_WIDTH: read pointer (binary / Gray); rptr_g_out goes to the write-side synchroniser.
REQ-013 Port data_out  out  WIDTH: first-word-fall-through (FWFT) output data.
REQ-014 Port valid_out  out  1: data_out holds a valid word.
REQ-015 Port empty_out  out  1: equals ~valid_out.
REQ-016 Port level_out  out  PTR_WIDTH: words available (memory plus output stage).
REQ-017 Port almost_empty_out  out  1: level_out <= AE_THRESH.
REQ-018 Port underflow_out  out  1: one-cycle pulse on an illegal pop.

Function
REQ-019 mem_has_data SHALL be combinational: rptr_g_out != wptr_g_sync_in.
REQ-020 A fetch SHALL assert rd_en_mem_out combinationally, drive raddr_out = rptr_b_out[PTR_WIDTH-2:0], and increment rptr_b_out modulo 2^PTR_WIDTH at the next edge.
- rptr_g_out SHALL be registered as (b>>1)^b of the next binary pointer.
REQ-021 The FSM SHALL have three states: EMPTY, LOAD (word is on rdata_mem_in), HOLD (word is in the holding register).
REQ-022 EMPTY transitions:
- mem_has_data = 1: fetch, go to LOAD.
- otherwise: stay in EMPTY, no fetch.
REQ-023 LOAD or HOLD with read_in = 0:
- LOAD: capture rdata_mem_in into the holding register, go to HOLD.
- HOLD: stay, no fetch.
REQ-024 LOAD or HOLD with read_in = 1:
- mem_has_data = 1: fetch, go to LOAD.
- otherwise: go to EMPTY.
REQ-025 Outputs from state:
- data_out = rdata_mem_in in LOAD, holding register otherwise.
- valid_out = (state != EMPTY).
- Throughput: one word per cycle.
REQ-026 Latency: a new wptr_g_sync_in value seen in EMPTY SHALL give valid_out = 1 at the second rising edge.
REQ-027 read_in while in EMPTY SHALL pulse underflow_out for one cycle and leave the pointers and state unchanged.
REQ-028 level_out SHALL be registered from gray2bin(wptr_g_sync_in) - rptr_b_out (modulo 2^PTR_WIDTH), plus 1 if the next state != EMPTY; almost_empty_out SHALL be registered in the same cycle.
REQ-029 Pointer wrap-around (binary 2^PTR_WIDTH-1 to 0) SHALL need no special handling; raddr_out wraps from depth-1 to 0.

Reset
REQ-030 While nrst_in = 0, asynchronously:
- state = EMPTY; rptr_b_out, rptr_g_out, level_out = 0.
- holding register and underflow_out = 0.
- almost_empty_out = 1; empty_out = 1.
REQ-031 Reset mid-operation SHALL discard the word in the output stage and any fetch in flight; the first edge after deassertion behaves as EMPTY.

Structure
REQ-032 State encodings SHALL live as localparams in the shared package fifo_pkg.
REQ-033 The block SHALL instantiate the existing gray2bin sub-module (N = PTR_WIDTH) to convert wptr_g_sync_in.

Verification (WIDTH=8, PTR_WIDTH=4)
REQ-034 Single word: wptr_g_sync_in 0000->0001, mem[0]=A5 -> next edge rd_en=1 and raddr=0; one cycle later valid_out=1, data_out=A5; pop -> empty_out=1, rptr_b=0001.
REQ-035 Burst: 8 words D0..D7, read_in held 1 -> D0..D7 on 8 consecutive cycles, then empty; rptr_b=1000, rptr_g=1100.
REQ-036 Stall: in HOLD, read_in=0 for 5 cycles while rdata_mem_in toggles -> data_out stable, no rd_en.
REQ-037 Underflow: read_in=1 while empty -> underflow_out high exactly 1 cycle; rptr unchanged.
REQ-038 Wrap: rptr_b 1111 -> 0000 -> rptr_g 1000 -> 0000, raddr 7 -> 0, data order preserved.
REQ-039 Reset in LOAD with 3 words stored -> all outputs at reset values immediately, before any clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-side output-stage state encodings.
package fifo_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    LOAD  = ST_LOAD,
    HOLD  = ST_HOLD
  } rd_state_e;

endpackage

// File: rtl/gray2bin.sv
// Gray-code to binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_async_read_ctrl.sv
// Read-side controller of an async FIFO with a first-word-fall-through output stage.
// The output stage is either fed straight from memory (LOAD) or from a holding register (HOLD).
module fifo_async_read_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4,
  parameter int AE_THRESH = 1
) (
  input  logic                 read_clk,
  input  logic                 nrst_in,
  input  logic                 read_in,
  input  logic [PTR_WIDTH-1:0] wptr_g_sync_in,
  input  logic [WIDTH-1:0]     rdata_mem_in,
  output logic                 rd_en_mem_out,
  output logic [PTR_WIDTH-2:0] raddr_out,
  output logic [PTR_WIDTH-1:0] rptr_b_out,
  output logic [PTR_WIDTH-1:0] rptr_g_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  output logic                 empty_out,
  output logic [PTR_WIDTH-1:0] level_out,
  output logic                 almost_empty_out,
  output logic                 underflow_out
);

  localparam logic [PTR_WIDTH-1:0] AE_LVL = PTR_WIDTH'(AE_THRESH);

  rd_state_e              state, state_next;
  logic [WIDTH-1:0]       hold_q;
  logic [PTR_WIDTH-1:0]   wptr_b;
  logic [PTR_WIDTH-1:0]   rptr_b_next;
  logic [PTR_WIDTH-1:0]   level_next;
  logic                   mem_has_data;
  logic                   fetch;
  logic                   capture;

  gray2bin #(.N(PTR_WIDTH)) u_wptr_g2b (
    .gray (wptr_g_sync_in),
    .bin  (wptr_b)
  );

  assign mem_has_data = (rptr_g_out != wptr_g_sync_in);

  always_comb begin
    state_next = state;
    fetch      = 1'b0;
    capture    = 1'b0;
    case (state)
      EMPTY: begin
        if (mem_has_data) begin
          fetch      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD, HOLD: begin
        if (read_in) begin
          if (mem_has_data) begin
            fetch      = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = EMPTY;
          end
        end else if (state == LOAD) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Level counts against the post-edge pointer so a word just fetched is
  // counted once, in the output stage, not also in memory.
  always_comb begin
    rptr_b_next = rptr_b_out + {{(PTR_WIDTH-1){1'b0}}, fetch};
    level_next  = wptr_b - rptr_b_next + {{(PTR_WIDTH-1){1'b0}}, (state_next != EMPTY)};
  end

  always_ff @(posedge read_clk or negedge nrst_in) begin
    if (!nrst_in) begin
      state            <= EMPTY;
      rptr_b_out       <= '0;
      rptr_g_out       <= '0;
      level_out        <= '0;
      almost_empty_out <= 1'b1;
      underflow_out    <= 1'b0;
      hold_q           <= '0;
    end else begin
      state            <= state_next;
      rptr_b_out       <= rptr_b_next;
      rptr_g_out       <= rptr_b_next ^ (rptr_b_next >> 1);
      level_out        <= level_next;
      almost_empty_out <= (level_next <= AE_LVL);
      underflow_out    <= read_in && (state == EMPTY);
      if (capture) begin
        hold_q <= rdata_mem_in;
      end
    end
  end

  assign rd_en_mem_out = fetch;
  assign raddr_out     = rptr_b_out[PTR_WIDTH-2:0];
  assign data_out      = (state == LOAD) ? rdata_mem_in : hold_q;
  assign valid_out     = (state != EMPTY);
  assign empty_out     = ~valid_out;

endmodule

// File: tb/tb_fifo_async_read_ctrl.sv
// Bench for fifo_async_read_ctrl: a behavioural write side and memory feed a scoreboard
// of expected words that is drained as the controller presents them.
module tb_fifo_async_read_ctrl;

  logic       read_clk = 1'b0;
  logic       nrst_in;
  logic       read_in;
  logic [3:0] wptr_g_sync_in;
  logic [7:0] rdata_mem_in;
  logic       rd_en_mem_out;
  logic [2:0] raddr_out;
  logic [3:0] rptr_b_out;
  logic [3:0] rptr_g_out;
  logic [7:0] data_out;
  logic       valid_out;
  logic       empty_out;
  logic [3:0] level_out;
  logic       almost_empty_out;
  logic       underflow_out;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] wbin;
  logic [7:0] mem [8];
  logic [7:0] rdata_q = 8'h00;
  logic [7:0] noise = 8'h00;
  logic [7:0] exp_q [$];

  always #5 read_clk = ~read_clk;

  always @(posedge read_clk) begin
    if (rd_en_mem_out) rdata_q <= mem[raddr_out];
  end
  assign rdata_mem_in = rdata_q ^ noise;

  fifo_async_read_ctrl #(.WIDTH(8), .PTR_WIDTH(4), .AE_THRESH(1)) dut (
    .read_clk         (read_clk),
    .nrst_in          (nrst_in),
    .read_in          (read_in),
    .wptr_g_sync_in   (wptr_g_sync_in),
    .rdata_mem_in     (rdata_mem_in),
    .rd_en_mem_out    (rd_en_mem_out),
    .raddr_out        (raddr_out),
    .rptr_b_out       (rptr_b_out),
    .rptr_g_out       (rptr_g_out),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .empty_out        (empty_out),
    .level_out        (level_out),
    .almost_empty_out (almost_empty_out),
    .underflow_out    (underflow_out)
  );

  task automatic push_word(input logic [7:0] d);
    mem[wbin[2:0]] = d;
    wbin           = wbin + 4'd1;
    wptr_g_sync_in = wbin ^ (wbin >> 1);
    exp_q.push_back(d);
  endtask

  task automatic apply_reset();
    nrst_in = 1'b0;
    read_in = 1'b0;
    noise   = 8'h00;
    wbin    = 4'd0;
    wptr_g_sync_in = 4'd0;
    exp_q.delete();
    @(negedge read_clk);
    nrst_in = 1'b1;
    @(negedge read_clk);
  endtask

  task automatic test_reset();
    nrst_in = 1'b0;
    read_in = 1'b0;
    noise   = 8'h00;
    wbin    = 4'd0;
    wptr_g_sync_in = 4'd0;
    repeat (2) @(negedge read_clk);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    vectors++; if (empty_out !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty_out); end
    vectors++; if (rptr_b_out !== 4'd0) begin miscompares++; $display("FAIL reset_rptr_b: got %b want 0000", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'd0) begin miscompares++; $display("FAIL reset_rptr_g: got %b want 0000", rptr_g_out); end
    vectors++; if (level_out !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level_out); end
    vectors++; if (almost_empty_out !== 1'b1) begin miscompares++; $display("FAIL reset_ae: got %b want 1", almost_empty_out); end
    vectors++; if (underflow_out !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow_out); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
    nrst_in = 1'b1;
    @(negedge read_clk);
  endtask

  task automatic test_single();
    push_word(8'hA5);
    #1;
    vectors++; if (rd_en_mem_out !== 1'b1) begin miscompares++; $display("FAIL single_rd_en: got %b want 1", rd_en_mem_out); end
    vectors++; if (raddr_out !== 3'd0) begin miscompares++; $display("FAIL single_raddr: got %0d want 0", raddr_out); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %b want 0", valid_out); end
    @(negedge read_clk);
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", valid_out); end
    vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL single_data: got %h want %h", data_out, exp_q[0]); end
    vectors++; if (level_out !== 4'd1) begin miscompares++; $display("FAIL single_level: got %0d want 1", level_out); end
    void'(exp_q.pop_front());
    read_in = 1'b1;
    @(negedge read_clk);
    read_in = 1'b0;
    vectors++; if (empty_out !== 1'b1) begin miscompares++; $display("FAIL single_empty: got %b want 1", empty_out); end
    vectors++; if (rptr_b_out !== 4'b0001) begin miscompares++; $display("FAIL single_rptr_b: got %b want 0001", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'b0001) begin miscompares++; $display("FAIL single_rptr_g: got %b want 0001", rptr_g_out); end
    vectors++; if (level_out !== 4'd0) begin miscompares++; $display("FAIL single_level_after: got %0d want 0", level_out); end
  endtask

  task automatic test_burst();
    int run = 0;
    int maxrun = 0;
    for (int i = 0; i < 8; i++) push_word(8'hD0 + 8'(i));
    for (int i = 0; i < 10 && !valid_out; i++) @(negedge read_clk);
    vectors++; if (level_out !== 4'd8) begin miscompares++; $display("FAIL burst_level: got %0d want 8", level_out); end
    vectors++; if (almost_empty_out !== 1'b0) begin miscompares++; $display("FAIL burst_ae: got %b want 0", almost_empty_out); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (exp_q.size() == 0) break;
      if (valid_out) begin
        vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL burst_data: got %h want %h", data_out, exp_q[0]); end
        void'(exp_q.pop_front());
        read_in = 1'b1;
        run++;
      end else begin
        read_in = 1'b0;
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      @(negedge read_clk);
    end
    read_in = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL burst_timeout: got %0d left want 0", exp_q.size()); end
    vectors++; if (maxrun != 8) begin miscompares++; $display("FAIL burst_throughput: got run %0d want 8", maxrun); end
    vectors++; if (empty_out !== 1'b1) begin miscompares++; $display("FAIL burst_empty: got %b want 1", empty_out); end
    vectors++; if (rptr_b_out !== 4'b1000) begin miscompares++; $display("FAIL burst_rptr_b: got %b want 1000", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'b1100) begin miscompares++; $display("FAIL burst_rptr_g: got %b want 1100", rptr_g_out); end
  endtask

  task automatic test_stall();
    push_word(8'h5A);
    push_word(8'hC3);
    for (int i = 0; i < 10 && !valid_out; i++) @(negedge read_clk);
    @(negedge read_clk);
    for (int i = 0; i < 5; i++) begin
      noise = 8'($urandom_range(1, 255));
      #1;
      vectors++; if (data_out !== 8'h5A) begin miscompares++; $display("FAIL stall_data: got %h want 5a", data_out); end
      vectors++; if (rd_en_mem_out !== 1'b0) begin miscompares++; $display("FAIL stall_rd_en: got %b want 0", rd_en_mem_out); end
      vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b want 1", valid_out); end
      @(negedge read_clk);
    end
    noise = 8'h00;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (exp_q.size() == 0) break;
      if (valid_out) begin
        vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL stall_drain: got %h want %h", data_out, exp_q[0]); end
        void'(exp_q.pop_front());
        read_in = 1'b1;
      end else begin
        read_in = 1'b0;
      end
      @(negedge read_clk);
    end
    read_in = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_underflow();
    logic [3:0] rb;
    rb = rptr_b_out;
    read_in = 1'b1;
    @(negedge read_clk);
    read_in = 1'b0;
    vectors++; if (underflow_out !== 1'b1) begin miscompares++; $display("FAIL underflow_pulse: got %b want 1", underflow_out); end
    vectors++; if (rptr_b_out !== rb) begin miscompares++; $display("FAIL underflow_rptr: got %b want %b", rptr_b_out, rb); end
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL underflow_valid: got %b want 0", valid_out); end
    @(negedge read_clk);
    vectors++; if (underflow_out !== 1'b0) begin miscompares++; $display("FAIL underflow_width: got %b want 0", underflow_out); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_raddr;
    int fetches = 0;
    bit first = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (exp_q.size() == 0) break;
      if (valid_out) begin
        vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL prewrap_data: got %h want %h", data_out, exp_q[0]); end
        void'(exp_q.pop_front());
        read_in = 1'b1;
      end else begin
        read_in = 1'b0;
      end
      @(negedge read_clk);
    end
    read_in = 1'b0;
    vectors++; if (rptr_b_out !== 4'b1111) begin miscompares++; $display("FAIL wrap_rptr_b_pre: got %b want 1111", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'b1000) begin miscompares++; $display("FAIL wrap_rptr_g_pre: got %b want 1000", rptr_g_out); end
    exp_raddr = 3'd7;
    for (int i = 0; i < 6; i++) push_word(8'hE0 + 8'(i));
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (exp_q.size() == 0) break;
      if (valid_out) begin
        if (first) begin
          first = 1'b0;
          vectors++; if (rptr_b_out !== 4'b0000) begin miscompares++; $display("FAIL wrap_rptr_b_mid: got %b want 0000", rptr_b_out); end
          vectors++; if (rptr_g_out !== 4'b0000) begin miscompares++; $display("FAIL wrap_rptr_g_mid: got %b want 0000", rptr_g_out); end
        end
        vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL wrap_data: got %h want %h", data_out, exp_q[0]); end
        void'(exp_q.pop_front());
        read_in = 1'b1;
      end else begin
        read_in = 1'b0;
      end
      #1;
      if (rd_en_mem_out) begin
        vectors++; if (raddr_out !== exp_raddr) begin miscompares++; $display("FAIL wrap_raddr: got %0d want %0d", raddr_out, exp_raddr); end
        exp_raddr = exp_raddr + 3'd1;
        fetches++;
      end
      @(negedge read_clk);
    end
    read_in = 1'b0;
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_timeout: got %0d left want 0", exp_q.size()); end
    vectors++; if (fetches != 6) begin miscompares++; $display("FAIL wrap_fetches: got %0d want 6", fetches); end
    vectors++; if (rptr_b_out !== 4'b0101) begin miscompares++; $display("FAIL wrap_rptr_b_post: got %b want 0101", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'b0111) begin miscompares++; $display("FAIL wrap_rptr_g_post: got %b want 0111", rptr_g_out); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) push_word(8'h70 + 8'(i));
    @(negedge read_clk);
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid: got %b want 1", valid_out); end
    #2;
    nrst_in = 1'b0;
    #1;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", valid_out); end
    vectors++; if (empty_out !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", empty_out); end
    vectors++; if (rptr_b_out !== 4'd0) begin miscompares++; $display("FAIL midrst_rptr_b: got %b want 0000", rptr_b_out); end
    vectors++; if (rptr_g_out !== 4'd0) begin miscompares++; $display("FAIL midrst_rptr_g: got %b want 0000", rptr_g_out); end
    vectors++; if (level_out !== 4'd0) begin miscompares++; $display("FAIL midrst_level: got %0d want 0", level_out); end
    vectors++; if (almost_empty_out !== 1'b1) begin miscompares++; $display("FAIL midrst_ae: got %b want 1", almost_empty_out); end
    vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h want 00", data_out); end
    wbin = 4'd0;
    wptr_g_sync_in = 4'd0;
    exp_q.delete();
    @(negedge read_clk);
    nrst_in = 1'b1;
    @(negedge read_clk);
    push_word(8'h3C);
    @(negedge read_clk);
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL midrst_after_valid: got %b want 1", valid_out); end
    vectors++; if (data_out !== exp_q[0]) begin miscompares++; $display("FAIL midrst_after_data: got %h want %h", data_out, exp_q[0]); end
    void'(exp_q.pop_front());
    read_in = 1'b1;
    @(negedge read_clk);
    read_in = 1'b0;
    vectors++; if (rptr_b_out !== 4'b0001) begin miscompares++; $display("FAIL midrst_after_rptr: got %b want 0001", rptr_b_out); end
    vectors++; if (empty_out !== 1'b1) begin miscompares++; $display("FAIL midrst_after_empty: got %b want 1", empty_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_burst();
    test_stall();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
